// File: rtl/iz_param_loader.sv
// iz_param_loader
// Serial-to-parallel loader for the Izhikevich neuron parameters a, b, c, d.
// A 40-bit frame is sent MSB-first as a, b, c, d, chk while load_mode is high.
// The frame is committed atomically only if it is exactly 40 bits long and
// chk == a^b^c^d^CHK_SEED. A rejected frame leaves the committed set untouched.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset (dominates enable)
//   enable        clock enable; when low all state holds, param_update drops
//   load_mode     frame gate, high while frame bits are presented
//   serial_data   frame bit, sampled on the rising clk edge
//   param_a..d    committed parameters (raw 8-bit values)
//   params_ready  sticky: a valid frame has been committed since reset
//   param_update  one-cycle pulse on each commit
//   load_err      result of the last completed frame (1 = rejected)
//   busy          high while the loader is not idle
module iz_param_loader #(
  parameter logic [7:0] DEF_A    = 8'h05,
  parameter logic [7:0] DEF_B    = 8'h33,
  parameter logic [7:0] DEF_C    = 8'hBF,
  parameter logic [7:0] DEF_D    = 8'h08,
  parameter logic [7:0] CHK_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load_mode,
  input  logic       serial_data,
  output logic [7:0] param_a,
  output logic [7:0] param_b,
  output logic [7:0] param_c,
  output logic [7:0] param_d,
  output logic       params_ready,
  output logic       param_update,
  output logic       load_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [5:0] FRAME_LEN = 6'd40;

  // Expected checksum for the four data bytes held in a full frame.
  function automatic logic [7:0] frame_chk(input logic [39:0] sr);
    return sr[39:32] ^ sr[31:24] ^ sr[23:16] ^ sr[15:8] ^ CHK_SEED;
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [39:0] sr_q, sr_d;
  logic [7:0]  pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
  logic        ready_q, ready_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        frame_ok_s;

  // Overlong frames set ovf_q, so a saturated count of 40 alone is not enough.
  assign frame_ok_s = (count_q == FRAME_LEN) && !ovf_q &&
                      (sr_q[7:0] == frame_chk(sr_q));

  // Next-state and output logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    sr_d    = sr_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pc_d    = pc_q;
    pd_d    = pd_q;
    ready_d = ready_q;
    err_d   = err_q;
    upd_d   = 1'b0;
    busy_d  = busy_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (load_mode) begin
            sr_d    = {sr_q[38:0], serial_data};
            count_d = 6'd1;
            ovf_d   = 1'b0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (load_mode) begin
            if (count_q < FRAME_LEN) begin
              sr_d    = {sr_q[38:0], serial_data};
              count_d = count_q + 6'd1;
            end else begin
              // Extra bits are not shifted; they only mark the frame bad.
              ovf_d = 1'b1;
            end
          end else begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          // load_mode is ignored here; a new frame must start from IDLE.
          state_d = IDLE;
          if (frame_ok_s) begin
            pa_d    = sr_q[39:32];
            pb_d    = sr_q[31:24];
            pc_d    = sr_q[23:16];
            pd_d    = sr_q[15:8];
            ready_d = 1'b1;
            err_d   = 1'b0;
            upd_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      busy_d = (state_d != IDLE);
    end else begin
      busy_d = busy_q;
    end
  end

  // State and output registers with synchronous reset to the defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 6'd0;
      ovf_q   <= 1'b0;
      sr_q    <= 40'd0;
      pa_q    <= DEF_A;
      pb_q    <= DEF_B;
      pc_q    <= DEF_C;
      pd_q    <= DEF_D;
      ready_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      sr_q    <= sr_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pc_q    <= pc_d;
      pd_q    <= pd_d;
      ready_q <= ready_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign param_a      = pa_q;
  assign param_b      = pb_q;
  assign param_c      = pc_q;
  assign param_d      = pd_q;
  assign params_ready = ready_q;
  assign param_update = upd_q;
  assign load_err     = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iz_param_loader.sv
// Testbench for iz_param_loader: directed frames, expected results queued by
// the stimulus process and checked by an independent monitor when busy falls.
module tb_iz_param_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_mode;
  logic       serial_data;
  logic [7:0] param_a, param_b, param_c, param_d;
  logic       params_ready, param_update, load_err, busy;

  iz_param_loader dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .param_a      (param_a),
    .param_b      (param_b),
    .param_c      (param_c),
    .param_d      (param_d),
    .params_ready (params_ready),
    .param_update (param_update),
    .load_err     (load_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] params;
    logic        ready;
    logic        err;
    logic        upd;
  } exp_t;

  localparam logic [31:0] DEFAULTS = 32'h0533BF08;
  localparam logic [47:0] F1       = 48'h00_021AC0106D;
  localparam logic [47:0] F1_BAD   = 48'h00_021AC0106C;
  localparam logic [47:0] F2       = 48'h00_7F8001FEA5;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_commit = 0;
  int          upd_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_params = DEFAULTS;
  logic        m_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the expected outcome of the next frame given a hand-stated verdict.
  task automatic expect_frame(input logic [31:0] data, input bit accept);
    exp_t e;
    if (accept) begin
      m_params = data;
      m_ready  = 1'b1;
      e = '{params: data, ready: 1'b1, err: 1'b0, upd: 1'b1};
      n_commit++;
    end else begin
      e = '{params: m_params, ready: m_ready, err: 1'b1, upd: 1'b0};
    end
    exp_q.push_back(e);
  endtask

  // Shift n bits of v MSB-first; optionally stall for 5 cycles after bit stall_after.
  task automatic shift_frame(input logic [47:0] v, input int n, input int stall_after);
    for (int i = n - 1; i >= 0; i--) begin
      if ((n - 1 - i) == stall_after) begin
        repeat (5) begin
          @(negedge clk);
          enable      = 1'b0;
          serial_data = ~serial_data;
        end
      end
      @(negedge clk);
      enable      = 1'b1;
      load_mode   = 1'b1;
      serial_data = v[i];
    end
    @(negedge clk);
    load_mode   = 1'b0;
    serial_data = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares outputs whenever a frame ends (busy falls).
  initial begin
    logic [31:0] cur_params;
    logic        busy_prev;
    exp_t        e;
    cur_params = DEFAULTS;
    busy_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (param_update === 1'b1) upd_cnt++;
        if (busy_prev === 1'b1 && busy === 1'b0) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame_end: got busy fall expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("params", {param_a, param_b, param_c, param_d}, e.params);
            check("params_ready", {31'd0, params_ready}, {31'd0, e.ready});
            check("load_err", {31'd0, load_err}, {31'd0, e.err});
            check("param_update", {31'd0, param_update}, {31'd0, e.upd});
            cur_params = e.params;
          end
        end else if (busy === 1'b1) begin
          check("params_stable", {param_a, param_b, param_c, param_d}, cur_params);
        end
        busy_prev = busy;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    load_mode   = 1'b0;
    serial_data = 1'b0;
    idle(2);
    check("reset_params", {param_a, param_b, param_c, param_d}, DEFAULTS);
    check("reset_ready", {31'd0, params_ready}, 32'd0);
    check("reset_err", {31'd0, load_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_update", {31'd0, param_update}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Valid frame.
    expect_frame(F1[39:8], 1'b1);
    shift_frame(F1, 40, -1);
    idle(4);

    // Bad checksum.
    expect_frame(F1_BAD[39:8], 1'b0);
    shift_frame(F1_BAD, 40, -1);
    idle(4);

    // 39-bit frame, then 41-bit frame.
    expect_frame(32'd0, 1'b0);
    shift_frame(F1 >> 1, 39, -1);
    idle(4);
    expect_frame(32'd0, 1'b0);
    shift_frame({F1[46:0], 1'b1}, 41, -1);
    idle(4);

    // Different valid frame clears load_err.
    expect_frame(F2[39:8], 1'b1);
    shift_frame(F2, 40, -1);
    idle(4);

    // 1-cycle load_mode pulse.
    expect_frame(32'd0, 1'b0);
    shift_frame(48'd1, 1, -1);
    idle(4);

    // Enable stall after bit 17.
    expect_frame(F1[39:8], 1'b1);
    shift_frame(F1, 40, 17);
    idle(4);

    // load_mode re-asserted during CHECK is ignored; next frame starts from IDLE.
    expect_frame(F2[39:8], 1'b1);
    expect_frame(F1[39:8], 1'b1);
    shift_frame(F2, 40, -1);
    @(negedge clk);
    load_mode   = 1'b1;
    serial_data = 1'b1;
    shift_frame(F1, 40, -1);
    idle(4);

    // Reset at bit 20 after a prior commit.
    for (int i = 39; i >= 20; i--) begin
      @(negedge clk);
      load_mode   = 1'b1;
      serial_data = F2[i];
    end
    exp_q.push_back('{params: DEFAULTS, ready: 1'b0, err: 1'b0, upd: 1'b0});
    m_params = DEFAULTS;
    m_ready  = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    load_mode = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Valid frame after reset.
    expect_frame(F1[39:8], 1'b1);
    shift_frame(F1, 40, -1);
    idle(6);

    check("queue_drained", exp_q.size(), 32'd0);
    check("update_pulses", upd_cnt, n_commit);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
